// File: rtl/tri_bus_ctrl.sv
// Half-duplex controller for a shared tri-state pin bus.
// Local writes drive the pins outward for DRIVE_CYC cycles. Local reads hand
// the pins to the external device for SAMPLE_DLY cycles and then sample them.
// Every transaction ends with TURN_CYC released cycles, so oe and ext_grant
// are never high together and IDLE is always a safe place to start from.
// Pending writes and reads are arbitrated round-robin.
module tri_bus_ctrl #(
    parameter int W          = 8,
    parameter int TURN_CYC   = 1,
    parameter int DRIVE_CYC  = 2,
    parameter int SAMPLE_DLY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid,
    input  logic [W-1:0] wr_data,
    output logic         wr_ready,
    input  logic         rd_req,
    output logic         rd_ready,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    inout  wire  [W-1:0] io_pin,
    output logic         oe,
    output logic         ext_grant,
    output logic         busy
);

    // The counter must hold the largest "cycles - 1" load value.
    localparam int MAX_AB = (TURN_CYC > DRIVE_CYC) ? TURN_CYC : DRIVE_CYC;
    localparam int MAX_C  = (MAX_AB > SAMPLE_DLY) ? MAX_AB : SAMPLE_DLY;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYC - 1);
    localparam logic [CW-1:0] DRIVE_LD  = CW'(DRIVE_CYC - 1);
    localparam logic [CW-1:0] SAMPLE_LD = CW'(SAMPLE_DLY - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] GRANT = 2'd2;
    localparam logic [1:0] TA    = 2'd3;

    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          oe_r;
    logic          oe_s;
    logic          grant_r;
    logic          grant_s;
    logic [W-1:0]  data_r;
    logic [W-1:0]  data_s;
    logic          rr_last_wr_r;
    logic          rr_last_wr_s;
    logic [W-1:0]  rd_data_r;
    logic [W-1:0]  rd_data_s;
    logic          rd_valid_r;
    logic          rd_valid_s;
    logic          wr_ready_s;
    logic          rd_ready_s;

    // Round-robin handshakes: only offered in IDLE and never while reset is held;
    // a tie goes to whichever side did not win last time (write after reset).
    always_comb begin
        wr_ready_s = 1'b0;
        rd_ready_s = 1'b0;
        if ((state_r == IDLE) && !rst) begin
            wr_ready_s = wr_valid && (!rd_req || !rr_last_wr_r);
            rd_ready_s = rd_req && (!wr_valid || rr_last_wr_r);
        end else begin
            wr_ready_s = 1'b0;
            rd_ready_s = 1'b0;
        end
    end

    // Next-state logic: the counter is loaded on every state entry and the
    // registered oe/ext_grant are computed together with the state they belong to.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        oe_s         = oe_r;
        grant_s      = grant_r;
        data_s       = data_r;
        rr_last_wr_s = rr_last_wr_r;
        rd_data_s    = rd_data_r;
        rd_valid_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (wr_ready_s) begin
                    state_s      = DRIVE;
                    cnt_s        = DRIVE_LD;
                    oe_s         = 1'b1;
                    grant_s      = 1'b0;
                    data_s       = wr_data;
                    rr_last_wr_s = 1'b1;
                end else if (rd_ready_s) begin
                    state_s      = GRANT;
                    cnt_s        = SAMPLE_LD;
                    oe_s         = 1'b0;
                    grant_s      = 1'b1;
                    rr_last_wr_s = 1'b0;
                end else begin
                    oe_s    = 1'b0;
                    grant_s = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = TA;
                    cnt_s   = TURN_LD;
                    oe_s    = 1'b0;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            GRANT: begin
                if (cnt_r == CNT_ZERO) begin
                    // Capture happens on the edge that ends the last grant cycle.
                    state_s    = TA;
                    cnt_s      = TURN_LD;
                    grant_s    = 1'b0;
                    rd_data_s  = io_pin;
                    rd_valid_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            TA: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
                oe_s    = 1'b0;
                grant_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset that also aborts a transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            oe_r         <= 1'b0;
            grant_r      <= 1'b0;
            data_r       <= {W{1'b0}};
            rr_last_wr_r <= 1'b0;
            rd_data_r    <= {W{1'b0}};
            rd_valid_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            oe_r         <= oe_s;
            grant_r      <= grant_s;
            data_r       <= data_s;
            rr_last_wr_r <= rr_last_wr_s;
            rd_data_r    <= rd_data_s;
            rd_valid_r   <= rd_valid_s;
        end
    end

    assign io_pin    = oe_r ? data_r : {W{1'bz}};
    assign oe        = oe_r;
    assign ext_grant = grant_r;
    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign wr_ready  = wr_ready_s;
    assign rd_ready  = rd_ready_s;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_tri_bus_ctrl.sv
// Bench for tri_bus_ctrl: directed phases plus random traffic checked against a
// transaction-level timeline model; a second instance with TURN_CYC=3 is
// watched for drive exclusivity and turnaround gaps.
module tb_tri_bus_ctrl;

    localparam int W    = 8;
    localparam int TURN = 1;
    localparam int DRV  = 2;
    localparam int SMP  = 2;
    localparam int NC   = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       rd_req = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] ext_val = 8'h00;

    wire       wr_ready, rd_ready, rd_valid, oe, ext_grant, busy;
    wire [7:0] rd_data;
    wire [7:0] io_pin;
    wire       wr_ready3, rd_ready3, rd_valid3, oe3, gr3, busy3;
    wire [7:0] rd_data3;
    wire [7:0] io3;

    // External device: drives the bus only while granted.
    assign io_pin = ext_grant ? ext_val : 8'bz;
    assign io3    = gr3 ? ext_val : 8'bz;

    tri_bus_ctrl #(.W(W), .TURN_CYC(TURN), .DRIVE_CYC(DRV), .SAMPLE_DLY(SMP)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .io_pin(io_pin), .oe(oe), .ext_grant(ext_grant), .busy(busy)
    );

    tri_bus_ctrl #(.W(W), .TURN_CYC(3), .DRIVE_CYC(DRV), .SAMPLE_DLY(SMP)) dut3 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready3),
        .rd_req(rd_req), .rd_ready(rd_ready3), .rd_data(rd_data3), .rd_valid(rd_valid3),
        .io_pin(io3), .oe(oe3), .ext_grant(gr3), .busy(busy3)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Timeline model: what each future cycle should look like, filled in at acceptance.
    bit         m_oe  [NC];
    bit         m_gr  [NC];
    bit         m_rv  [NC];
    bit         m_cap [NC];
    logic [7:0] m_dat [NC];
    logic [7:0] m_rd     = 8'h00;
    int         free_cyc = 0;
    bit         rr       = 1'b0;
    bit         log_en   = 1'b0;
    bit         order[$];

    task automatic run_cycle();
        bit idle, exp_wr, exp_rd;
        @(negedge clk);
        idle   = (cyc >= free_cyc) && !rst;
        exp_wr = idle && wr_valid && (!rd_req || !rr);
        exp_rd = idle && rd_req && !exp_wr;
        check_eq("oe", {31'd0, oe}, {31'd0, m_oe[cyc]});
        check_eq("ext_grant", {31'd0, ext_grant}, {31'd0, m_gr[cyc]});
        check_eq("rd_valid", {31'd0, rd_valid}, {31'd0, m_rv[cyc]});
        check_eq("rd_data", {24'd0, rd_data}, {24'd0, m_rd});
        check_eq("busy", {31'd0, busy}, {31'd0, (cyc < free_cyc)});
        check_eq("wr_ready", {31'd0, wr_ready}, {31'd0, exp_wr});
        check_eq("rd_ready", {31'd0, rd_ready}, {31'd0, exp_rd});
        if (m_oe[cyc]) begin
            check_eq("io_pin", {24'd0, io_pin}, {24'd0, m_dat[cyc]});
        end
        if (log_en && wr_valid && wr_ready) order.push_back(1'b1);
        if (log_en && rd_req && rd_ready) order.push_back(1'b0);
        if (rst) begin
            for (int k = cyc + 1; k < NC; k++) begin
                m_oe[k] = 1'b0; m_gr[k] = 1'b0; m_rv[k] = 1'b0; m_cap[k] = 1'b0;
            end
            free_cyc = cyc + 1;
            rr       = 1'b0;
            m_rd     = 8'h00;
        end else begin
            if (m_cap[cyc]) m_rd = ext_val;
            if (exp_wr) begin
                for (int k = 1; k <= DRV; k++) begin
                    m_oe[cyc + k]  = 1'b1;
                    m_dat[cyc + k] = wr_data;
                end
                free_cyc = cyc + DRV + TURN + 1;
                rr       = 1'b1;
            end else if (exp_rd) begin
                for (int k = 1; k <= SMP; k++) m_gr[cyc + k] = 1'b1;
                m_cap[cyc + SMP]    = 1'b1;
                m_rv[cyc + SMP + 1] = 1'b1;
                free_cyc = cyc + SMP + TURN + 1;
                rr       = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Turnaround monitor on the TURN_CYC=3 instance.
    bit mon_en   = 1'b0;
    bit prev_act = 1'b0;
    bit had_fall = 1'b0;
    bit block    = 1'b1;
    int low_run  = 0;

    always @(negedge clk) begin
        bit act;
        if (mon_en) begin
            act = oe3 | gr3;
            check_eq("excl", {31'd0, oe3 & gr3}, 32'd0);
            if (!prev_act && act && had_fall) begin
                check_eq("gap3", {31'd0, (low_run >= 3)}, 32'd1);
                had_fall = 1'b0;
            end
            if (!act) low_run = prev_act ? 1 : low_run + 1;
            if (prev_act && !act) had_fall = !block;
            if (rst) begin
                block    = 1'b1;
                had_fall = 1'b0;
            end else if (!act) begin
                block = 1'b0;
            end
            prev_act = act;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held with a pending write, then released.
        rst = 1'b1; wr_valid = 1'b1; wr_data = 8'hF0;
        repeat (3) run_cycle();
        rst = 1'b0;
        run_cycle();
        wr_valid = 1'b0;
        repeat (6) run_cycle();

        // Single read of 55.
        ext_val = 8'h55; rd_req = 1'b1;
        run_cycle();
        rd_req = 1'b0;
        repeat (6) run_cycle();
        check_eq("rd_hold", {24'd0, rd_data}, 32'h55);

        // Contention: both requests held.
        wr_valid = 1'b1; wr_data = 8'hA5; rd_req = 1'b1; ext_val = 8'h3C; log_en = 1'b1;
        repeat (24) run_cycle();
        log_en = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
        repeat (5) run_cycle();
        check_eq("order_len", {31'd0, (order.size() >= 4)}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < order.size()) check_eq("order", {31'd0, order[i]}, {31'd0, (i % 2 == 0)});
        end
        check_eq("rd_3c", {24'd0, rd_data}, 32'h3C);

        // Reset in the first DRIVE cycle, then a clean write.
        wr_valid = 1'b1; wr_data = 8'h81;
        run_cycle();
        wr_valid = 1'b0; rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        run_cycle();
        wr_valid = 1'b1; wr_data = 8'h7E;
        run_cycle();
        wr_valid = 1'b0;
        repeat (6) run_cycle();

        // Random traffic with occasional resets.
        repeat (400) begin
            rst      = ($urandom_range(0, 59) == 0);
            wr_valid = $urandom_range(0, 1) == 1;
            rd_req   = $urandom_range(0, 1) == 1;
            wr_data  = 8'($urandom);
            ext_val  = 8'($urandom);
            run_cycle();
        end
        rst = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
        repeat (8) run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
